// File: rtl/state_change_logger_if.sv
// Drain-side valid/ready port of the state change logger.
interface state_change_logger_if #(
  parameter int unsigned TS_W = 8
) ();
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [TS_W+2:0] OUT_DATA;

  modport master (output OUT_VALID, output OUT_DATA, input OUT_READY);
  modport slave  (input OUT_VALID, input OUT_DATA, output OUT_READY);
endinterface

// File: rtl/state_change_logger.sv
// Timestamps every change of the 3-bit JK state bus and queues it in a
// first-word-fall-through FIFO; events lost to a full FIFO are counted.
module state_change_logger #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN,
  input  logic [2:0]             Q_IN,
  input  logic                   CLR_OVF,
  state_change_logger_if.master  out_if,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic [7:0]             OVF_CNT
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = TS_W + 3;

  logic [2:0]      prev_q_q, prev_q_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic event_c, pop_c, push_c, drop_c, full_c, empty_c;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign event_c = EN && (Q_IN != prev_q_q);
  assign pop_c   = !empty_c && out_if.OUT_READY;
  // A full FIFO can still accept an event when the head leaves on the same edge.
  assign push_c  = event_c && (!full_c || pop_c);
  assign drop_c  = event_c && full_c && !pop_c;

  always_comb begin
    prev_q_d = Q_IN;
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Clear wins over a coincident drop.
    if (CLR_OVF)                       ovf_d = '0;
    else if (drop_c && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q_q <= '0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      prev_q_q <= prev_q_d;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_ptr_q] <= {ts_q, Q_IN};
  end

  assign out_if.OUT_VALID = !empty_c;
  assign out_if.OUT_DATA  = empty_c ? '0 : mem_q[rd_ptr_q];
  assign FULL             = full_c;
  assign EMPTY            = empty_c;
  assign COUNT            = count_q;
  assign OVF_CNT          = ovf_q;

endmodule
